// File: rtl/bioee_scan_pkg.sv
// Shared types and defaults for the bioee scan-chain sequencer: the FSM state
// encoding and the per-state control-output pattern.
package bioee_scan_pkg;

  localparam int DEF_CHAIN_LEN = 64;
  localparam int DEF_NUM_LANES = 5;
  localparam int DEF_HALF_DIV  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_WAIT,
    ST_LOW,
    ST_HIGH,
    ST_LATCH,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic scan_clk;
    logic scan_resetn;
    logic scan_latch;
    logic in_ready;
    logic busy;
    logic done;
  } ctrl_t;

  // Control outputs held while in state s; at most one chip strobe is ever active.
  function automatic ctrl_t ctrl_for(state_e s);
    ctrl_t c;
    c = '{scan_clk: 1'b0, scan_resetn: 1'b1, scan_latch: 1'b0,
          in_ready: 1'b0, busy: 1'b1, done: 1'b0};
    case (s)
      ST_IDLE:  c.busy        = 1'b0;
      ST_CRST:  c.scan_resetn = 1'b0;
      ST_WAIT:  c.in_ready    = 1'b1;
      ST_HIGH:  c.scan_clk    = 1'b1;
      ST_LATCH: c.scan_latch  = 1'b1;
      ST_DONE:  c.done        = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  // States whose duration is set by the shared phase timer.
  function automatic logic is_timed(state_e s);
    return (s == ST_CRST) || (s == ST_LOW) || (s == ST_HIGH) || (s == ST_LATCH);
  endfunction

endpackage

// File: rtl/bioee_phase_timer.sv
// HALF_DIV-cycle down-counter: load restarts a phase, expire flags its last cycle.
module bioee_phase_timer #(
  parameter int HALF_DIV = 4
) (
  input  logic clkin,
  input  logic resetn,
  input  logic load,
  output logic expire
);

  localparam int              CW     = $clog2(HALF_DIV + 1);
  localparam logic [CW-1:0]   RELOAD = CW'(HALF_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/bioee_scan_sequencer.sv
// Drives a multi-lane chip scan chain: optional chain reset, CHAIN_LEN bit
// shifts with a divided scan clock, then a latch strobe and a done pulse.
module bioee_scan_sequencer
  import bioee_scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int HALF_DIV  = DEF_HALF_DIV
) (
  input  logic                           clkin,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           chain_rst_req,
  input  logic                           abort,
  input  logic                           in_valid,
  input  logic [NUM_LANES-1:0]           in_data,
  output logic                           in_ready,
  output logic                           scan_clk,
  output logic                           scan_resetn,
  output logic                           scan_latch,
  output logic [NUM_LANES-1:0]           scan_data,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

  localparam int            BW   = $clog2(CHAIN_LEN + 1);
  localparam logic [BW-1:0] LAST = BW'(CHAIN_LEN);

  state_e        state;
  ctrl_t         ctrl;
  logic          expire;
  logic          load;
  logic [BW-1:0] bit_next;

  // Untimed states keep the timer primed so every timed state starts a full phase.
  assign load     = !is_timed(state) || expire;
  assign bit_next = bit_count + BW'(1);

  bioee_phase_timer #(
    .HALF_DIV (HALF_DIV)
  ) u_timer (
    .clkin  (clkin),
    .resetn (resetn),
    .load   (load),
    .expire (expire)
  );

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      ctrl      <= ctrl_for(ST_IDLE);
      scan_data <= '0;
      bit_count <= '0;
    end else if (abort && state != ST_IDLE) begin
      state     <= ST_IDLE;
      ctrl      <= ctrl_for(ST_IDLE);
      scan_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            bit_count <= '0;
            if (chain_rst_req) begin
              state <= ST_CRST;
              ctrl  <= ctrl_for(ST_CRST);
            end else begin
              state <= ST_WAIT;
              ctrl  <= ctrl_for(ST_WAIT);
            end
          end
        end
        ST_CRST: begin
          if (expire) begin
            state <= ST_WAIT;
            ctrl  <= ctrl_for(ST_WAIT);
          end
        end
        ST_WAIT: begin
          if (in_valid) begin
            scan_data <= in_data;
            state     <= ST_LOW;
            ctrl      <= ctrl_for(ST_LOW);
          end
        end
        ST_LOW: begin
          if (expire) begin
            state <= ST_HIGH;
            ctrl  <= ctrl_for(ST_HIGH);
          end
        end
        ST_HIGH: begin
          if (expire) begin
            bit_count <= bit_next;
            if (bit_next == LAST) begin
              state <= ST_LATCH;
              ctrl  <= ctrl_for(ST_LATCH);
            end else begin
              state <= ST_WAIT;
              ctrl  <= ctrl_for(ST_WAIT);
            end
          end
        end
        ST_LATCH: begin
          if (expire) begin
            state <= ST_DONE;
            ctrl  <= ctrl_for(ST_DONE);
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          ctrl      <= ctrl_for(ST_IDLE);
          scan_data <= '0;
        end
        default: begin
          state     <= ST_IDLE;
          ctrl      <= ctrl_for(ST_IDLE);
          scan_data <= '0;
        end
      endcase
    end
  end

  assign scan_clk    = ctrl.scan_clk;
  assign scan_resetn = ctrl.scan_resetn;
  assign scan_latch  = ctrl.scan_latch;
  assign in_ready    = ctrl.in_ready;
  assign busy        = ctrl.busy;
  assign done        = ctrl.done;

endmodule

// File: tb/tb_bioee_scan_sequencer.sv
// Bench for bioee_scan_sequencer: directed scenario table plus randomized
// sequences compared cycle by cycle against a timeline model.
module tb_bioee_scan_sequencer;

  localparam int CL = 4;
  localparam int NL = 5;
  localparam int HD = 2;
  localparam int BW = $clog2(CL + 1);

  logic          clkin = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          chain_rst_req = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [NL-1:0] in_data = '0;
  logic          in_ready, scan_clk, scan_resetn, scan_latch, busy, done;
  logic [NL-1:0] scan_data;
  logic [BW-1:0] bit_count;

  int total = 0;
  int bad   = 0;

  always #5 clkin = ~clkin;

  bioee_scan_sequencer #(
    .CHAIN_LEN (CL),
    .NUM_LANES (NL),
    .HALF_DIV  (HD)
  ) dut (
    .clkin         (clkin),
    .resetn        (resetn),
    .start         (start),
    .chain_rst_req (chain_rst_req),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .scan_clk      (scan_clk),
    .scan_resetn   (scan_resetn),
    .scan_latch    (scan_latch),
    .scan_data     (scan_data),
    .busy          (busy),
    .done          (done),
    .bit_count     (bit_count)
  );

  logic [31:0] obs;
  assign obs = 32'({scan_clk, scan_resetn, scan_latch, in_ready, busy, done, scan_data, bit_count});

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] idle_word(input logic [BW-1:0] bc);
    return 32'({6'b010000, NL'(0), bc});
  endfunction

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  // ---------------- directed scenario table ----------------
  typedef struct {
    string name;
    int rst_req, stall_from, stall_len, abort_cyc;
    int exp_done, exp_bc, exp_pulses, exp_latch, exp_rstlo, exp_rst_first, idle_cyc;
  } vec_t;

  function automatic vec_t mk(input string n, input int rr, sf, sl, ac, ed, eb, ep, el, er, erf, ic);
    vec_t v;
    v.name = n; v.rst_req = rr; v.stall_from = sf; v.stall_len = sl; v.abort_cyc = ac;
    v.exp_done = ed; v.exp_bc = eb; v.exp_pulses = ep; v.exp_latch = el;
    v.exp_rstlo = er; v.exp_rst_first = erf; v.idle_cyc = ic;
    return v;
  endfunction

  vec_t vecs[4];

  // Start is applied in cycle 0; observations for cycle c follow the c-th edge.
  task automatic run_scenario(input vec_t v);
    int done_cyc = -1, done_n = 0, pulses = 0, latch_n = 0, rstlo = 0, rst_first = -1;
    int stall_bad = 0, excl_bad = 0;
    logic prev_clk = 1'b0;
    logic [NL-1:0] held = '0;
    start = 1'b1; chain_rst_req = (v.rst_req != 0); abort = 1'b0;
    in_valid = 1'b1; in_data = NL'($urandom);
    for (int c = 1; c <= 45; c++) begin
      step();
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (scan_clk && !prev_clk) pulses++;
      prev_clk = scan_clk;
      if (scan_latch) latch_n++;
      if (!scan_resetn) begin
        rstlo++;
        if (rst_first < 0) rst_first = c;
      end
      if (int'(scan_clk) + int'(scan_latch) + int'(!scan_resetn) > 1) excl_bad++;
      if (v.stall_len > 0 && c == v.stall_from) held = scan_data;
      if (v.stall_len > 0 && c >= v.stall_from && c < v.stall_from + v.stall_len)
        if (!in_ready || scan_clk || scan_data !== held) stall_bad++;
      if (c == v.idle_cyc) check({v.name, "_idle"}, obs, idle_word(BW'(v.exp_bc)));
      start = 1'b0; chain_rst_req = 1'b0;
      abort = (c == v.abort_cyc);
      in_valid = !(c >= v.stall_from && c < v.stall_from + v.stall_len);
      in_data = NL'($urandom);
    end
    abort = 1'b0;
    check({v.name, "_done_cycle"}, done_cyc, v.exp_done);
    check({v.name, "_done_pulses"}, done_n, (v.exp_done < 0) ? 0 : 1);
    check({v.name, "_bit_count"}, 32'(bit_count), v.exp_bc);
    check({v.name, "_clk_pulses"}, pulses, v.exp_pulses);
    check({v.name, "_latch_cycles"}, latch_n, v.exp_latch);
    check({v.name, "_rst_low_cycles"}, rstlo, v.exp_rstlo);
    check({v.name, "_rst_first"}, rst_first, v.exp_rst_first);
    check({v.name, "_stall_violations"}, stall_bad, 0);
    check({v.name, "_strobe_overlap"}, excl_bad, 0);
  endtask

  // ---------------- randomized timeline model ----------------
  typedef struct {
    logic start, rst_req, abort, in_valid;
    logic [NL-1:0] in_data;
    logic ck, rn, lt, rd, bz, dn;
    logic [NL-1:0] data;
    logic [BW-1:0] bc;
  } cyc_t;

  cyc_t          plan[$];
  logic [NL-1:0] m_data;
  logic [BW-1:0] m_bc;

  task automatic push(input logic ck, rn, lt, rd, bz, dn, input logic iv, input logic st);
    cyc_t e;
    e.start = st; e.rst_req = 1'($urandom); e.abort = 1'b0;
    e.in_valid = iv; e.in_data = NL'($urandom);
    e.ck = ck; e.rn = rn; e.lt = lt; e.rd = rd; e.bz = bz; e.dn = dn;
    e.data = m_data; e.bc = m_bc;
    plan.push_back(e);
  endtask

  function automatic logic rnd_start();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic build_seq();
    int sidx, k;
    logic crst;
    logic [NL-1:0] w;
    m_data = '0;
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
      push(0, 1, 0, 0, 0, 0, 1'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        plan[plan.size()-1].start = 1'b1;
        plan[plan.size()-1].abort = 1'b1;
      end
    end
    crst = 1'($urandom);
    push(0, 1, 0, 0, 0, 0, 1'($urandom), 1'b1);
    plan[plan.size()-1].rst_req = crst;
    m_bc = '0;
    sidx = plan.size();
    if (crst) for (int i = 0; i < HD; i++) push(0, 0, 0, 0, 1, 0, 1'($urandom), rnd_start());
    for (int b = 0; b < CL; b++) begin
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) push(0, 1, 0, 1, 1, 0, 1'b0, rnd_start());
      w = NL'($urandom);
      push(0, 1, 0, 1, 1, 0, 1'b1, rnd_start());
      plan[plan.size()-1].in_data = w;
      m_data = w;
      for (int i = 0; i < HD; i++) push(0, 1, 0, 0, 1, 0, 1'($urandom), rnd_start());
      for (int i = 0; i < HD; i++) push(1, 1, 0, 0, 1, 0, 1'($urandom), rnd_start());
      m_bc = m_bc + BW'(1);
    end
    for (int i = 0; i < HD; i++) push(0, 1, 1, 0, 1, 0, 1'($urandom), rnd_start());
    push(0, 1, 0, 0, 1, 1, 1'($urandom), rnd_start());
    m_data = '0;
    if ($urandom_range(0, 3) == 0) begin
      k = sidx + int'($urandom_range(0, plan.size() - sidx - 1));
      plan[k].abort = 1'b1;
      m_bc = plan[k].bc;
      while (plan.size() > k + 1) void'(plan.pop_back());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = mk("basic",     0, 0, 0,  0, 23, 4, 4, 2, 0, -1, 24);
    vecs[1] = mk("chain_rst", 1, 0, 0,  0, 25, 4, 4, 2, 2,  1, 26);
    vecs[2] = mk("stall",     0, 6, 10, 0, 33, 4, 4, 2, 0, -1, 34);
    vecs[3] = mk("abort",     0, 0, 0, 14, -1, 2, 3, 0, 0, -1, 15);

    // Reset state and no self-start after release.
    step(); step();
    check("reset_idle", obs, idle_word('0));
    resetn = 1'b1;
    repeat (3) step();
    check("post_reset_idle", obs, idle_word('0));

    foreach (vecs[i]) begin
      run_scenario(vecs[i]);
      repeat (2) step();
    end

    // Asynchronous reset in the middle of a LOW phase.
    start = 1'b1; chain_rst_req = 1'b0; in_valid = 1'b1;
    step();
    start = 1'b0;
    step();
    check("midlow_pre", 32'({scan_clk, busy, in_ready}), 32'h2);
    #2 resetn = 1'b0;
    #1 check("async_reset", obs, idle_word('0));
    @(negedge clkin);
    resetn = 1'b1;
    repeat (4) step();
    check("no_self_start", obs, idle_word('0));
    run_scenario(vecs[0]);
    step();

    // Randomized sequences against the timeline model.
    m_bc = BW'(CL);
    for (int s = 0; s < 25; s++) build_seq();
    m_data = '0;
    push(0, 1, 0, 0, 0, 0, 1'b0, 1'b0);
    push(0, 1, 0, 0, 0, 0, 1'b0, 1'b0);
    foreach (plan[i]) begin
      check($sformatf("trace[%0d]", i), obs,
            32'({plan[i].ck, plan[i].rn, plan[i].lt, plan[i].rd, plan[i].bz, plan[i].dn,
                 plan[i].data, plan[i].bc}));
      start = plan[i].start; chain_rst_req = plan[i].rst_req; abort = plan[i].abort;
      in_valid = plan[i].in_valid; in_data = plan[i].in_data;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
